// File: rtl/pp_chunk_buf_pkg.sv
// Shared types and default widths for the path-parser chunk buffer.
package pp_chunk_buf_pkg;

  localparam int unsigned PP_DATA_PATH_NBITS   = 64;
  localparam int unsigned PP_CHUNK_LEN_NBITS   = 16;
  localparam int unsigned PP_META_RCI_NBITS    = 8;
  localparam int unsigned PP_CHUNK_SLOTS_NBITS = 2;

  // Per-slot life cycle: FREE -> FILLING -> READY -> FREE (or FREE -> READY
  // for a single-beat chunk).
  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_FILLING = 2'd1,
    SLOT_READY   = 2'd2
  } slot_state_e;

endpackage

// File: rtl/pp_chunk_slot_ctrl.sv
// Slot controller: per-slot FSMs, write/read slot pointers, word address,
// occupancy and the registered in_ready for pp_chunk_buf.
module pp_chunk_slot_ctrl
  import pp_chunk_buf_pkg::*;
#(
  parameter int unsigned  NUM_SLOTS = 4,
  parameter int unsigned  DEPTH_W   = 5,
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS),
  localparam int unsigned OCC_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_match,
  input  logic              i_eop,
  input  logic              i_release,
  output logic              o_in_ready,
  output logic              o_first,
  output logic              o_ovf_beat,
  output logic              o_wen,
  output logic              o_eop_acc,
  output logic [SLOT_W-1:0] o_wr_slot,
  output logic [SLOT_W-1:0] o_rd_slot,
  output logic [DEPTH_W-1:0] o_waddr,
  output logic              o_wr_open,
  output logic              o_wr_filling,
  output logic              o_slot_valid,
  output logic [OCC_W-1:0]  o_occupancy
);

  slot_state_e       r_state   [NUM_SLOTS];
  slot_state_e       w_state_n [NUM_SLOTS];
  logic [SLOT_W-1:0] r_wr_slot;
  logic [SLOT_W-1:0] r_rd_slot;
  logic [SLOT_W-1:0] w_wr_slot_n;
  logic [SLOT_W-1:0] w_rd_slot_n;
  // Extra MSB marks the saturated "slot full" word count.
  logic [DEPTH_W:0]  r_waddr;
  logic              r_in_ready;
  logic              w_in_ready_n;
  logic [OCC_W-1:0]  r_occ;
  logic              w_acc;
  logic              w_first;
  logic              w_rel;
  logic              w_ovf;

  assign w_acc   = i_match & r_in_ready;
  assign w_first = w_acc & (r_state[r_wr_slot] == SLOT_FREE);
  assign w_rel   = i_release & (r_state[r_rd_slot] == SLOT_READY);
  assign w_ovf   = w_acc & r_waddr[DEPTH_W];

  // Next-state for all slot FSMs and pointers; the write and release targets
  // are never the same slot (one is READY, the other is not).
  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) w_state_n[i] = r_state[i];
    w_wr_slot_n = r_wr_slot;
    w_rd_slot_n = r_rd_slot;
    if (w_acc) begin
      w_state_n[r_wr_slot] = i_eop ? SLOT_READY : SLOT_FILLING;
      if (i_eop) w_wr_slot_n = r_wr_slot + 1'b1;
    end
    if (w_rel) begin
      w_state_n[r_rd_slot] = SLOT_FREE;
      w_rd_slot_n          = r_rd_slot + 1'b1;
    end
    w_in_ready_n = (w_state_n[w_wr_slot_n] != SLOT_READY);
  end

  // State, pointer, word address, occupancy and in_ready registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) r_state[i] <= SLOT_FREE;
      r_wr_slot  <= '0;
      r_rd_slot  <= '0;
      r_waddr    <= '0;
      r_in_ready <= 1'b1;
      r_occ      <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) r_state[i] <= w_state_n[i];
      r_wr_slot  <= w_wr_slot_n;
      r_rd_slot  <= w_rd_slot_n;
      r_in_ready <= w_in_ready_n;
      if (w_acc) begin
        if (i_eop)                 r_waddr <= '0;
        else if (!r_waddr[DEPTH_W]) r_waddr <= r_waddr + 1'b1;
      end
      if (w_first && !w_rel)      r_occ <= r_occ + 1'b1;
      else if (!w_first && w_rel) r_occ <= r_occ - 1'b1;
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_first      = w_first;
  assign o_ovf_beat   = w_ovf;
  assign o_wen        = w_acc & ~r_waddr[DEPTH_W];
  assign o_eop_acc    = w_acc & i_eop;
  assign o_wr_slot    = r_wr_slot;
  assign o_rd_slot    = r_rd_slot;
  assign o_waddr      = r_waddr[DEPTH_W-1:0];
  assign o_wr_open    = (r_state[r_wr_slot] != SLOT_READY);
  assign o_wr_filling = (r_state[r_wr_slot] == SLOT_FILLING);
  assign o_slot_valid = (r_state[r_rd_slot] == SLOT_READY);
  assign o_occupancy  = r_occ;

endmodule

// File: rtl/pp_chunk_buf.sv
// N-slot chunk buffer in front of the path parser. Stores chunks addressed
// to PP_ID, tags them with RCI metadata and presents them in arrival order.
// Optional statistics outputs: define PP_CHUNK_BUF_STATS_EN.
module pp_chunk_buf
  import pp_chunk_buf_pkg::*;
#(
  parameter int unsigned  PP_ID     = 0,
  parameter int unsigned  NUM_SLOTS = 4,
  parameter int unsigned  DEPTH_W   = 5,
  parameter int unsigned  DATA_W    = PP_DATA_PATH_NBITS,
  parameter int unsigned  LEN_W     = PP_CHUNK_LEN_NBITS,
  parameter int unsigned  ID_W      = 2,
  parameter int unsigned  RCI_W     = PP_META_RCI_NBITS,
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS),
  localparam int unsigned OCC_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_eop,
  input  logic [LEN_W-1:0]   in_len,
  input  logic [ID_W-1:0]    in_id,
  output logic               in_ready,
  input  logic               meta_valid,
  input  logic [RCI_W-1:0]   meta_rci,
  output logic               slot_valid,
  output logic [LEN_W-1:0]   slot_len,
  output logic [RCI_W-1:0]   slot_rci,
  output logic               slot_err,
  input  logic               rd_en,
  input  logic [DEPTH_W-1:0] rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               slot_release,
  output logic [OCC_W-1:0]   occupancy
`ifdef PP_CHUNK_BUF_STATS_EN
  ,
  output logic [31:0]        stat_chunks,
  output logic [15:0]        stat_ovf,
  output logic [15:0]        stat_viol
`endif
);

  logic                w_match;
  logic                w_meta;
  logic                w_first;
  logic                w_ovf;
  logic                w_wen;
  logic                w_eop_acc;
  logic [SLOT_W-1:0]   w_wr_slot;
  logic [SLOT_W-1:0]   w_rd_slot;
  logic [DEPTH_W-1:0]  w_waddr;
  logic                w_wr_open;
  logic                w_wr_filling;

  logic [DATA_W-1:0]   r_mem [NUM_SLOTS << DEPTH_W];
  logic [DATA_W-1:0]   r_rd_data;
  logic [LEN_W-1:0]    r_len [NUM_SLOTS];
  logic [RCI_W-1:0]    r_rci [NUM_SLOTS];
  logic                r_err [NUM_SLOTS];

  assign w_match = in_valid   & (in_id == ID_W'(PP_ID));
  assign w_meta  = meta_valid & (in_id == ID_W'(PP_ID));

  pp_chunk_slot_ctrl #(
    .NUM_SLOTS (NUM_SLOTS),
    .DEPTH_W   (DEPTH_W)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .i_match      (w_match),
    .i_eop        (in_eop),
    .i_release    (slot_release),
    .o_in_ready   (in_ready),
    .o_first      (w_first),
    .o_ovf_beat   (w_ovf),
    .o_wen        (w_wen),
    .o_eop_acc    (w_eop_acc),
    .o_wr_slot    (w_wr_slot),
    .o_rd_slot    (w_rd_slot),
    .o_waddr      (w_waddr),
    .o_wr_open    (w_wr_open),
    .o_wr_filling (w_wr_filling),
    .o_slot_valid (slot_valid),
    .o_occupancy  (occupancy)
  );

  // Chunk storage write port: one word per accepted, non-overflowed beat.
  always_ff @(posedge clk) begin
    if (w_wen) r_mem[{w_wr_slot, w_waddr}] <= in_data;
  end

  // Registered read of the head slot; holds its value while rd_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_rd_data <= '0;
    else if (rd_en) r_rd_data <= r_mem[{w_rd_slot, rd_addr}];
  end

  // Per-slot metadata: length on eop, overflow flag, RCI from the meta port.
  // Meta lands in the write slot whenever it is FREE or FILLING, so meta
  // arriving after eop naturally targets the next chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        r_len[i] <= '0;
        r_rci[i] <= '0;
        r_err[i] <= 1'b0;
      end
    end else begin
      if (w_eop_acc)   r_len[w_wr_slot] <= in_len;
      if (w_first)     r_err[w_wr_slot] <= 1'b0;
      else if (w_ovf)  r_err[w_wr_slot] <= 1'b1;
      if (w_meta && w_wr_open) r_rci[w_wr_slot] <= meta_rci;
    end
  end

  assign rd_data  = r_rd_data;
  assign slot_len = r_len[w_rd_slot];
  assign slot_rci = r_rci[w_rd_slot];
  assign slot_err = r_err[w_rd_slot];

`ifdef PP_CHUNK_BUF_STATS_EN
  logic        w_viol;
  logic        w_chunk_ovf;
  logic [31:0] r_stat_chunks;
  logic [15:0] r_stat_ovf;
  logic [15:0] r_stat_viol;

  assign w_viol      = w_match & ~in_ready;
  assign w_chunk_ovf = w_eop_acc & (w_ovf | (w_wr_filling & r_err[w_wr_slot]));

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_chunks <= '0;
      r_stat_ovf    <= '0;
      r_stat_viol   <= '0;
    end else begin
      if (w_eop_acc   && (r_stat_chunks != '1)) r_stat_chunks <= r_stat_chunks + 1'b1;
      if (w_chunk_ovf && (r_stat_ovf    != '1)) r_stat_ovf    <= r_stat_ovf + 1'b1;
      if (w_viol      && (r_stat_viol   != '1)) r_stat_viol   <= r_stat_viol + 1'b1;
    end
  end

  assign stat_chunks = r_stat_chunks;
  assign stat_ovf    = r_stat_ovf;
  assign stat_viol   = r_stat_viol;
`endif

endmodule
